kbd_entry_buf: RTL and testbench
================================

# kbd_entry_buf

Parametrised keypad entry buffer. It consumes raw PS/2 set-2 scan bytes from the PS/2 receiver and tracks make, break, extended-prefix and typematic-repeat sequences, so each physical key press registers exactly once. It accumulates numeric keypad digits into a BCD shift buffer of configurable depth, supports backspace, clear and commit (with a one-cycle valid pulse), and feeds the alarm/time controller with a committed BCD value.

## Interface
- DIGITS, 4: number of BCD digits held; buffer width is 4*DIGITS; legal range 1..8.
- FILL, 4'hF: nibble value for empty digit positions.
- FULL_MODE, 0: behaviour when a digit arrives with the buffer full. 0 = shift (oldest digit dropped). 1 = reject (digit discarded, overflow pulses).

- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  asynchronous, active-high reset.
- scan_code  in  8  scan byte from the PS/2 receiver; valid only when scan_strobe=1.
- scan_strobe  in  1  one-cycle pulse per received scan byte.
- key_buffer  out  4*DIGITS  live BCD entry; newest digit in [3:0].
- digit_count  out  4  number of digits entered, 0..DIGITS.
- entry_value  out  4*DIGITS  BCD value captured at the last commit.
- entry_valid  out  1  one-cycle pulse when entry_value updates.
- overflow  out  1  one-cycle pulse on a rejected digit (FULL_MODE=1 only).
- key  out  8  last accepted keypad make code; 8'h00 if none.

## Operation
- Keycodes (keycodes.vh): KP_0..KP_9 = 70,69,72,7A,6B,73,74,6C,75,7D. KP_STAR=7C (commit). KP_MINUS=7B (backspace). KP_PLUS=79 (clear). KP_KEY_RELEASED=F0. Extended prefix=E0.
- Decoder FSM, advanced only on scan_strobe:
  - IDLE: F0 → BREAK. E0 → EXT. Keypad code → accept, held ← code, go HELD. Any other code → ignored, stay IDLE.
  - HELD: F0 → BREAK. E0 → EXT. Code == held → typematic repeat, ignored. Different keypad code → accept, held ← code. Any other code → ignored.
  - BREAK: the next byte is the released code. If it equals held → IDLE, else return to the prior state (IDLE or HELD). Never an accept.
  - EXT: F0 → EXT_BREAK. Any other byte is discarded → return to the prior state.
  - EXT_BREAK: next byte discarded → return to the prior state.
- Accept actions (applied in the same edge as the decision):
  - Digit with count<DIGITS: buffer ← {buffer[4*DIGITS-5:0], bcd}; count+1.
  - Digit with count==DIGITS: FULL_MODE=0 shifts the same way and count stays DIGITS. FULL_MODE=1 leaves the buffer unchanged and pulses overflow.
  - KP_MINUS with count>0: buffer ← {FILL, buffer[4*DIGITS-1:4]}; count−1. With count=0: no change.
  - KP_PLUS: buffer ← all FILL; count ← 0.
  - KP_STAR: entry_value ← buffer; entry_valid pulses; buffer ← all FILL; count ← 0. Commit with count=0 is legal and still pulses, with entry_value all FILL.
  - key ← accepted code for every accept, including STAR, MINUS and PLUS.
- For DIGITS=1, the shift reduces to replacing the single nibble.

## Timing
- Reset values: key_buffer all FILL; digit_count 0; entry_value all FILL; entry_valid 0; overflow 0; key 8'h00; FSM IDLE; held 8'h00.
- Latency: every output reflects a strobed byte on the first posedge after the strobe cycle (1-cycle latency). There is no combinational path from scan_code to any output.
- entry_valid and overflow are high for exactly one cycle and are otherwise 0.
- Back-to-back strobes on consecutive cycles must be handled, with one byte processed per cycle.
- Reset asserted mid-sequence (e.g. in BREAK) returns everything to the reset state immediately. The next byte is then decoded from IDLE.
- scan_code is ignored whenever scan_strobe=0.

## Test plan
- DIGITS=4, FULL_MODE=0. Send 69 F0 69, 72 F0 72, 7A F0 7A, 6B F0 6B, 73 F0 73 → key_buffer=16'h2345, digit_count=4, key=73.
- Typematic: send 69 69 69 F0 69 → key_buffer=16'hFFF1, count=1. Then send 69 again → 16'hFF11.
- Backspace/clear: after entering 1,2,3, send 7B F0 7B → 16'hFF12, count=2. Then 79 F0 79 → 16'hFFFF, count=0. Then 7B on empty → no change.
- Commit: enter 1,2,3,4 then 7C F0 7C → entry_valid high for 1 cycle, exactly one cycle after the 7C strobe. entry_value=16'h1234; key_buffer=16'hFFFF; count=0.
- FULL_MODE=1: enter 5 digits 1..5 → key_buffer=16'h1234; overflow pulses once on the 5th digit.
- Extended/noise: send E0 70, then E0 F0 70, then 1C → buffer unchanged and key=00. Assert reset while in BREAK → all outputs return to reset values. Then 70 F0 70 → 16'hFFF0.

Source files
------------

// File: rtl/kbd_entry_buf.sv
// Keypad entry buffer: decodes PS/2 set-2 make/break/extended/typematic sequences
// and accumulates keypad digits into a BCD shift buffer with backspace/clear/commit.
module kbd_entry_buf #(
   parameter int         DIGITS    = 4,
   parameter logic [3:0] FILL      = 4'hF,
   parameter bit         FULL_MODE = 1'b0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [7:0]            scan_code,
   input  logic                  scan_strobe,
   output logic [4*DIGITS-1:0]   key_buffer,
   output logic [3:0]            digit_count,
   output logic [4*DIGITS-1:0]   entry_value,
   output logic                  entry_valid,
   output logic                  overflow,
   output logic [7:0]            key
);

   localparam int         W        = 4*DIGITS;
   localparam logic [W-1:0] FILL_ALL = {DIGITS{FILL}};
   localparam logic [3:0] DMAX     = 4'(DIGITS);

   localparam logic [7:0] KP_STAR  = 8'h7C;
   localparam logic [7:0] KP_MINUS = 8'h7B;
   localparam logic [7:0] KP_PLUS  = 8'h79;
   localparam logic [7:0] KEY_REL  = 8'hF0;
   localparam logic [7:0] EXT_PFX  = 8'hE0;

   typedef enum logic [2:0] {S_IDLE, S_HELD, S_BREAK, S_EXT, S_EXT_BREAK} state_t;

   state_t     state;
   logic       ret_held;
   logic [7:0] held;

   logic         is_digit, is_kp;
   logic [3:0]   bcd;
   logic [W+3:0] shift_ext, back_ext;
   logic [W-1:0] shifted, backspaced;

   always_comb begin
      is_digit = 1'b1;
      bcd      = 4'd0;
      case (scan_code)
         8'h70: bcd = 4'd0;
         8'h69: bcd = 4'd1;
         8'h72: bcd = 4'd2;
         8'h7A: bcd = 4'd3;
         8'h6B: bcd = 4'd4;
         8'h73: bcd = 4'd5;
         8'h74: bcd = 4'd6;
         8'h6C: bcd = 4'd7;
         8'h75: bcd = 4'd8;
         8'h7D: bcd = 4'd9;
         default: is_digit = 1'b0;
      endcase
      is_kp = is_digit || scan_code == KP_STAR || scan_code == KP_MINUS
              || scan_code == KP_PLUS;
   end

   // Width-extended concatenations keep the DIGITS=1 case a plain nibble replace.
   assign shift_ext  = {key_buffer, bcd};
   assign shifted    = shift_ext[W-1:0];
   assign back_ext   = {FILL, key_buffer};
   assign backspaced = back_ext[W+3:4];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_IDLE;
         ret_held    <= 1'b0;
         held        <= 8'h00;
         key_buffer  <= FILL_ALL;
         digit_count <= 4'd0;
         entry_value <= FILL_ALL;
         entry_valid <= 1'b0;
         overflow    <= 1'b0;
         key         <= 8'h00;
      end else begin
         entry_valid <= 1'b0;
         overflow    <= 1'b0;
         if (scan_strobe) begin
            case (state)
               S_IDLE, S_HELD: begin
                  if (scan_code == KEY_REL) begin
                     ret_held <= (state == S_HELD);
                     state    <= S_BREAK;
                  end else if (scan_code == EXT_PFX) begin
                     ret_held <= (state == S_HELD);
                     state    <= S_EXT;
                  end else if (is_kp && !(state == S_HELD && scan_code == held)) begin
                     held  <= scan_code;
                     state <= S_HELD;
                     key   <= scan_code;
                     if (is_digit) begin
                        if (digit_count < DMAX) begin
                           key_buffer  <= shifted;
                           digit_count <= digit_count + 4'd1;
                        end else if (FULL_MODE) begin
                           overflow <= 1'b1;
                        end else begin
                           key_buffer <= shifted;
                        end
                     end else if (scan_code == KP_MINUS) begin
                        if (digit_count != 4'd0) begin
                           key_buffer  <= backspaced;
                           digit_count <= digit_count - 4'd1;
                        end
                     end else if (scan_code == KP_PLUS) begin
                        key_buffer  <= FILL_ALL;
                        digit_count <= 4'd0;
                     end else begin
                        entry_value <= key_buffer;
                        entry_valid <= 1'b1;
                        key_buffer  <= FILL_ALL;
                        digit_count <= 4'd0;
                     end
                  end
               end
               S_BREAK:
                  state <= (scan_code == held || !ret_held) ? S_IDLE : S_HELD;
               S_EXT:
                  if (scan_code == KEY_REL) state <= S_EXT_BREAK;
                  else state <= ret_held ? S_HELD : S_IDLE;
               S_EXT_BREAK:
                  state <= ret_held ? S_HELD : S_IDLE;
               default:
                  state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_kbd_entry_buf.sv
// Scoreboard bench for kbd_entry_buf: shift-mode and reject-mode instances share stimulus.
module tb_kbd_entry_buf;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  scan_code;
   logic        scan_strobe;

   logic [15:0] kb0, ev0, kb1, ev1;
   logic [3:0]  dc0, dc1;
   logic        vld0, vld1, ovf0, ovf1;
   logic [7:0]  key0, key1;

   always #5 clk = ~clk;

   kbd_entry_buf #(.DIGITS(4), .FILL(4'hF), .FULL_MODE(1'b0)) dut0 (
      .clk(clk), .reset(reset), .scan_code(scan_code), .scan_strobe(scan_strobe),
      .key_buffer(kb0), .digit_count(dc0), .entry_value(ev0), .entry_valid(vld0),
      .overflow(ovf0), .key(key0));

   kbd_entry_buf #(.DIGITS(4), .FILL(4'hF), .FULL_MODE(1'b1)) dut1 (
      .clk(clk), .reset(reset), .scan_code(scan_code), .scan_strobe(scan_strobe),
      .key_buffer(kb1), .digit_count(dc1), .entry_value(ev1), .entry_valid(vld1),
      .overflow(ovf1), .key(key1));

   typedef struct {
      string       tag;
      logic [15:0] kb;
      logic [3:0]  dc;
      logic [7:0]  key;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] commit_q[$];
   int          checks   = 0;
   int          failures = 0;
   int          ovf0_cyc = 0;
   int          ovf1_cyc = 0;
   int          commits  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Caller is at a negedge; consecutive calls give back-to-back strobes.
   task automatic send(input logic [7:0] b);
      scan_code   = b;
      scan_strobe = 1'b1;
      @(negedge clk);
      scan_strobe = 1'b0;
   endtask

   task automatic press(input logic [7:0] b);
      send(b); send(8'hF0); send(b);
   endtask

   task automatic push_exp(input string tag, input logic [15:0] kb, input logic [3:0] dc,
                           input logic [7:0] k);
      exp_t e;
      e.tag = tag; e.kb = kb; e.dc = dc; e.key = k;
      exp_q.push_back(e);
   endtask

   task automatic pop_chk();
      exp_t e;
      if (exp_q.size() == 0) begin
         chk("sb_empty", 1, 0);
      end else begin
         e = exp_q.pop_front();
         chk({e.tag, "_buf"}, kb0, e.kb);
         chk({e.tag, "_cnt"}, dc0, e.dc);
         chk({e.tag, "_key"}, key0, e.key);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   always @(negedge clk) begin
      if (ovf0) ovf0_cyc++;
      if (ovf1) ovf1_cyc++;
      if (vld0) begin
         commits++;
         if (commit_q.size() == 0) chk("commit_unexp", vld0, 1'b0);
         else chk("commit_val", ev0, commit_q.pop_front());
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; scan_code = 8'h00; scan_strobe = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      push_exp("rst", 16'hFFFF, 4'd0, 8'h00);
      pop_chk();
      chk("rst_ev", ev0, 16'hFFFF);
      chk("rst_vld", vld0, 1'b0);
      chk("rst_ovf", ovf0, 1'b0);

      // five digits: shift mode drops the oldest, reject mode keeps 1234
      push_exp("shift5", 16'h2345, 4'd4, 8'h73);
      press(8'h69); press(8'h72); press(8'h7A); press(8'h6B); press(8'h73);
      pop_chk();
      chk("rej5_buf", kb1, 16'h1234);
      chk("rej5_cnt", dc1, 4'd4);
      chk("rej5_ovf_cyc", ovf1_cyc, 1);

      push_exp("clr", 16'hFFFF, 4'd0, 8'h79);
      press(8'h79);
      pop_chk();
      chk("clr_rej_buf", kb1, 16'hFFFF);

      // typematic repeats, then release of a different key keeps the hold
      push_exp("typem", 16'hFFF1, 4'd1, 8'h69);
      send(8'h69); send(8'h69); send(8'h69);
      send(8'hF0); send(8'h72); send(8'h69);
      send(8'hF0); send(8'h69);
      pop_chk();
      push_exp("typem2", 16'hFF11, 4'd2, 8'h69);
      send(8'h69);
      pop_chk();
      send(8'hF0); send(8'h69);

      push_exp("ent123", 16'hF123, 4'd3, 8'h7A);
      press(8'h79); press(8'h69); press(8'h72); press(8'h7A);
      pop_chk();
      push_exp("bksp", 16'hFF12, 4'd2, 8'h7B);
      press(8'h7B);
      pop_chk();
      push_exp("clr2", 16'hFFFF, 4'd0, 8'h79);
      press(8'h79);
      pop_chk();
      push_exp("bksp_empty", 16'hFFFF, 4'd0, 8'h7B);
      press(8'h7B);
      pop_chk();

      // commit 1234 with one-cycle latency and one-cycle pulse
      press(8'h69); press(8'h72); press(8'h7A); press(8'h6B);
      commit_q.push_back(16'h1234);
      send(8'h7C);
      chk("commit_lat", vld0, 1'b1);
      send(8'hF0);
      chk("commit_width", vld0, 1'b0);
      send(8'h7C);
      push_exp("post_commit", 16'hFFFF, 4'd0, 8'h7C);
      pop_chk();
      chk("commit_hold", ev0, 16'h1234);

      commit_q.push_back(16'hFFFF);
      press(8'h7C);
      chk("commit_cnt", commits, 2);
      chk("commit_q_empty", commit_q.size(), 0);

      // extended sequences and unrelated codes are noise
      do_reset();
      @(negedge clk);
      push_exp("ext_noise", 16'hFFFF, 4'd0, 8'h00);
      send(8'hE0); send(8'h70);
      send(8'hE0); send(8'hF0); send(8'h70);
      send(8'h1C);
      pop_chk();

      // reset while in BREAK must forget the pending release
      press(8'h69);
      send(8'hF0);
      reset = 1'b1;
      #1;
      chk("arst_buf", kb0, 16'hFFFF);
      chk("arst_key", key0, 8'h00);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      push_exp("after_rst", 16'hFFF0, 4'd1, 8'h70);
      press(8'h70);
      pop_chk();

      chk("ovf_shift_none", ovf0_cyc, 0);
      chk("ovf_rej_total", ovf1_cyc, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
